vpu_op_issuer: RTL and testbench



---
 rtl/vpu_pkg.sv | 22 ++
 rtl/vpu_sat_cntr.sv | 42 ++++
 rtl/vpu_op_issuer.sv | 150 +++++++++++++++
 tb/tb_vpu_op_issuer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared VPU types and constants.
// Used by the op issuer and its decoder-side consumers.
package vpu_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam int unsigned RESP_TAG_W = 4;
  localparam int unsigned RESP_LAT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } issuer_state_e;

  typedef struct packed {
    logic [RESP_TAG_W-1:0] tag;
    logic                  err;
    logic [RESP_LAT_W-1:0] lat;
  } vpu_resp_t;

endpackage

// File: rtl/vpu_sat_cntr.sv
// Saturating up-counter with synchronous clear and enable.
// reached_o flags that the count equals TARGET.
module vpu_sat_cntr #(
  parameter int unsigned W      = 8,
  parameter int unsigned TARGET = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         reached_o
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] TGT = W'(TARGET);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over enable; hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign reached_o = (cnt_q == TGT);

endmodule

// File: rtl/vpu_op_issuer.sv
// Start/done initiator for one VPU execution counter.
// One op in flight; tagged response with latency and timeout.
module vpu_op_issuer
  import vpu_pkg::*;
#(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned LAT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             start_o,
  input  logic             done_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             resp_err_o,
  output logic [LAT_W-1:0] resp_lat_o,
  output logic             spurious_o
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LAT_MAX = (32'd1 << LAT_W) - 32'd1;

  issuer_state_e    state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             spur_q, spur_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic             lat_full;
  logic             tmo_hit;
  logic [LAT_W-1:0] lat_cnt;
  logic [TMO_W-1:0] tmo_cnt_unused;

  // Both counters run from the start_o cycle onwards,
  // so in wait cycle k after start they both read k.
  assign cnt_en = (state_q == S_ISSUE) || (state_q == S_WAIT);

  vpu_sat_cntr #(
    .W      (LAT_W),
    .TARGET (LAT_MAX)
  ) u_lat_cntr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en & ~lat_full),
    .cnt_o     (lat_cnt),
    .reached_o (lat_full)
  );

  vpu_sat_cntr #(
    .W      (TMO_W),
    .TARGET (TIMEOUT_CYCLES)
  ) u_tmo_cntr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .cnt_o     (tmo_cnt_unused),
    .reached_o (tmo_hit)
  );

  // Next state, response capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    err_d        = err_q;
    lat_d        = lat_q;
    spur_d       = spur_q;
    cnt_clr      = 1'b0;
    req_ready_o  = 1'b0;
    start_o      = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (done_i) begin
          spur_d = 1'b1;
        end
        if (req_valid_i) begin
          tag_d   = req_tag_i;
          cnt_clr = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_o = 1'b1;
        if (done_i) begin
          err_d   = 1'b0;
          lat_d   = '0;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_i) begin
          err_d   = 1'b0;
          lat_d   = lat_cnt;
          state_d = S_RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          lat_d   = lat_cnt;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (done_i) begin
          spur_d = 1'b1;
        end
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
      spur_q  <= spur_d;
    end
  end

  assign resp_tag_o = tag_q;
  assign resp_err_o = err_q;
  assign resp_lat_o = lat_q;
  assign spurious_o = spur_q;

endmodule

// File: tb/tb_vpu_op_issuer.sv
// Bench for vpu_op_issuer: directed and random ops
// against a cycle-count reference model.
module tb_vpu_op_issuer;

  localparam int T  = 8;
  localparam int LW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, start, done;
  logic       resp_valid, resp_ready, resp_err, spur;
  logic [3:0] req_tag, resp_tag;
  logic [7:0] resp_lat;

  logic       s_req_valid, s_req_ready, s_start, s_done;
  logic       s_resp_valid, s_resp_ready, s_resp_err, s_spur;
  logic [3:0] s_req_tag, s_resp_tag;
  logic [2:0] s_resp_lat;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_spur = 1'b0;

  always #5 clk = ~clk;

  vpu_op_issuer #(
    .TAG_W(4), .TIMEOUT_CYCLES(T), .LAT_W(LW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_tag_i(req_tag), .start_o(start), .done_i(done),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_tag_o(resp_tag), .resp_err_o(resp_err),
    .resp_lat_o(resp_lat), .spurious_o(spur)
  );

  vpu_op_issuer #(
    .TAG_W(4), .TIMEOUT_CYCLES(64), .LAT_W(3)
  ) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(s_req_valid), .req_ready_o(s_req_ready),
    .req_tag_i(s_req_tag), .start_o(s_start), .done_i(s_done),
    .resp_valid_o(s_resp_valid), .resp_ready_i(s_resp_ready),
    .resp_tag_o(s_resp_tag), .resp_err_o(s_resp_err),
    .resp_lat_o(s_resp_lat), .spurious_o(s_spur)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // d = done delay after start (-1: never). Returns cycles from
  // start to resp_valid, error flag and saturated latency.
  function automatic void model(input int d, input int tmo,
                                input int lw, output int cyc,
                                output logic err, output int lat);
    int raw;
    int mx;
    mx = (1 << lw) - 1;
    if (d >= 0 && d <= tmo) begin
      err = 1'b0;
      raw = d;
    end else begin
      err = 1'b1;
      raw = tmo;
    end
    cyc = raw + 1;
    lat = (raw > mx) ? mx : raw;
  endfunction

  task automatic do_op(input logic [3:0] tag, input int d,
                       input int bp, input bit sr);
    int   cyc, ecyc, elat;
    logic eerr;
    bit   got, bad_busy, bad_hold;
    model(d, T, LW, ecyc, eerr, elat);
    req_valid = 1'b1;
    req_tag   = tag;
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_tag   = 4'($urandom);
    chk("start_pulse", start, 1);
    chk("ready_low_issue", req_ready, 0);
    done     = (d == 0);
    cyc      = 0;
    got      = 0;
    bad_busy = 0;
    while (!got && cyc < T + 4) begin
      @(negedge clk);
      cyc++;
      done = 1'b0;
      if (resp_valid) begin
        got = 1;
      end else begin
        if (start || req_ready) bad_busy = 1;
        done = (cyc == d);
      end
    end
    chk("resp_seen", got, 1);
    chk("resp_cycle", cyc, ecyc);
    chk("busy_outputs", bad_busy, 0);
    req_valid = 1'b1;
    req_tag   = ~tag;
    bad_hold  = 0;
    for (int i = 0; i < bp; i++) begin
      done = sr && (i == 0);
      if (!resp_valid || resp_tag !== tag || resp_err !== eerr ||
          resp_lat !== 8'(elat) || req_ready || start)
        bad_hold = 1;
      @(negedge clk);
    end
    done = 1'b0;
    if (sr && bp > 0) exp_spur = 1'b1;
    chk("resp_hold", bad_hold, 0);
    chk("resp_valid", resp_valid, 1);
    chk("resp_tag", resp_tag, tag);
    chk("resp_err", resp_err, eerr);
    chk("resp_lat", resp_lat, elat);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("idle_after_hs", {resp_valid, start, req_ready}, 3'b001);
    chk("spurious", spur, exp_spur);
  endtask

  task automatic sat_op(input int d);
    int   cyc, ecyc, elat;
    logic eerr;
    bit   got;
    model(d, 64, 3, ecyc, eerr, elat);
    s_req_valid = 1'b1;
    @(negedge clk);
    s_req_valid = 1'b0;
    chk("sat_start", s_start, 1);
    s_done = (d == 0);
    cyc    = 0;
    got    = 0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      cyc++;
      s_done = 1'b0;
      if (s_resp_valid) got = 1;
      else s_done = (cyc == d);
    end
    chk("sat_resp_cycle", cyc, ecyc);
    chk("sat_tag", s_resp_tag, s_req_tag);
    chk("sat_err", s_resp_err, eerr);
    chk("sat_lat", s_resp_lat, elat);
    s_resp_ready = 1'b1;
    @(negedge clk);
    s_resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_tag      = 4'h0;
    done         = 1'b0;
    resp_ready   = 1'b0;
    s_req_valid  = 1'b0;
    s_req_tag    = 4'hA;
    s_done       = 1'b0;
    s_resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", req_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_tag", resp_tag, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_lat", resp_lat, 0);
    chk("rst_spur", spur, 0);

    do_op(4'h5, 5, 0, 0);
    do_op(4'h9, 0, 0, 0);
    do_op(4'h3, -1, 0, 0);

    done = 1'b1;
    @(negedge clk);
    done     = 1'b0;
    exp_spur = 1'b1;
    chk("late_done_spur", spur, 1);
    chk("late_done_idle", {resp_valid, start, req_ready}, 3'b001);

    do_op(4'hC, T, 0, 0);
    do_op(4'h7, T + 1, 0, 0);
    do_op(4'hE, 3, 10, 0);
    do_op(4'h1, 2, 3, 1);

    req_valid = 1'b1;
    req_tag   = 4'h6;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    exp_spur = 1'b0;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_start", start, 0);
    chk("midrst_spur", spur, 0);
    chk("midrst_tag", resp_tag, 0);
    chk("midrst_lat", resp_lat, 0);

    do_op(4'h2, 1, 0, 0);
    do_op(4'hB, 4, 1, 0);

    for (int i = 0; i < 24; i++) begin
      do_op(4'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
            int'($urandom_range(0, 3)), 0);
    end

    sat_op(12);
    sat_op(5);
    sat_op(0);
    chk("sat_spur", s_spur, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
